// File: rtl/riscv_wb_stage_pkg.sv
// riscv_constants: shared types and constants for the kana-riscv writeback path.
//   wb_sel_t    - writeback source select (ALU, MEM, PC, CSR)
//   LB..LWU     - RV load funct3 codes
//   wb_state_t  - writeback stage FSM states
//   rf_write_en - register-file write qualifier (x0 is never written)
package riscv_constants;

  localparam int WB_SEL_W = 2;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC  = 2'd2,
    WB_CSR = 2'd3
  } wb_sel_t;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } wb_state_t;

  // Architectural register x0 is hard-wired to zero, so a write to it is dropped.
  function automatic logic rf_write_en(input logic we, input logic [4:0] addr);
    return we && (addr != 5'd0);
  endfunction

endpackage

// File: rtl/riscv_wb_stage_load_ext.sv
// riscv_load_ext: combinational load alignment and sign/zero extension.
//   funct3  - RV load type
//   addr_lo - byte offset of the load within the memory word
//   rdata   - raw data-memory word
//   ext     - aligned, extended register value
// Misaligned offsets are not checked; the low bits are used as given.
module riscv_load_ext
  import riscv_constants::*;
#(
  parameter int WORD_LENGTH = 32,
  localparam int LANE_W = $clog2(WORD_LENGTH / 8)
) (
  input  logic [2:0]             funct3,
  input  logic [LANE_W-1:0]      addr_lo,
  input  logic [WORD_LENGTH-1:0] rdata,
  output logic [WORD_LENGTH-1:0] ext
);

  logic [LANE_W-1:0]      half_off_s;
  logic [LANE_W-1:0]      word_off_s;
  logic [WORD_LENGTH-1:0] byte_sh_s;
  logic [WORD_LENGTH-1:0] half_sh_s;
  logic [WORD_LENGTH-1:0] word_sh_s;

  // Round the offset down to the containing half/word; at 32 bits the word offset is always 0.
  assign half_off_s = (addr_lo >> 1) << 1;
  assign word_off_s = (addr_lo >> 2) << 2;

  // Move the selected lane down to bit 0 (offsets are in bytes, so scale by 8).
  assign byte_sh_s = rdata >> {addr_lo, 3'b000};
  assign half_sh_s = rdata >> {half_off_s, 3'b000};
  assign word_sh_s = rdata >> {word_off_s, 3'b000};

  // Extension per load type; 64-bit-only codes fall back to raw data in a 32-bit build.
  always_comb begin
    ext = rdata;
    case (funct3)
      LB:  ext = WORD_LENGTH'($signed(byte_sh_s[7:0]));
      LBU: ext = WORD_LENGTH'(byte_sh_s[7:0]);
      LH:  ext = WORD_LENGTH'($signed(half_sh_s[15:0]));
      LHU: ext = WORD_LENGTH'(half_sh_s[15:0]);
      LW: begin
        if (WORD_LENGTH == 64) begin
          ext = WORD_LENGTH'($signed(word_sh_s[31:0]));
        end else begin
          ext = rdata;
        end
      end
      LWU: begin
        if (WORD_LENGTH == 64) begin
          ext = WORD_LENGTH'(word_sh_s[31:0]);
        end else begin
          ext = rdata;
        end
      end
      LD:      ext = rdata;
      default: ext = rdata;
    endcase
  end

endmodule

// File: rtl/riscv_wb_stage.sv
// riscv_wb_stage: registered writeback stage of the kana-riscv core.
//   clk, rst_n           - clock, asynchronous active-low reset
//   in_valid / in_ready  - handshake with the MEM stage
//   wb_sel, rd_we, rd_addr, alu_out, pc_plus4, csr_dout - retiring instruction
//   ld_funct3, ld_addr_lo, dmem_rvalid, dmem_rdata      - load type and memory response
//   rf_we, rf_waddr, rf_wdata   - register-file write port (1-cycle pulse)
//   load_pending, load_rd       - hazard info while a load waits for memory
//   retire, retire_cnt          - retire pulse and wrapping retired-instruction count
module riscv_wb_stage
  import riscv_constants::*;
#(
  parameter int WORD_LENGTH  = 32,
  parameter int RETIRE_CNT_W = 64,
  localparam int LANE_W = $clog2(WORD_LENGTH / 8)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WB_SEL_W-1:0]     wb_sel,
  input  logic                    rd_we,
  input  logic [4:0]              rd_addr,
  input  logic [WORD_LENGTH-1:0]  alu_out,
  input  logic [WORD_LENGTH-1:0]  pc_plus4,
  input  logic [WORD_LENGTH-1:0]  csr_dout,
  input  logic [2:0]              ld_funct3,
  input  logic [LANE_W-1:0]       ld_addr_lo,
  input  logic                    dmem_rvalid,
  input  logic [WORD_LENGTH-1:0]  dmem_rdata,
  output logic                    rf_we,
  output logic [4:0]              rf_waddr,
  output logic [WORD_LENGTH-1:0]  rf_wdata,
  output logic                    load_pending,
  output logic [4:0]              load_rd,
  output logic                    retire,
  output logic [RETIRE_CNT_W-1:0] retire_cnt
);

  wb_state_t               state_r;
  logic                    lat_we_r;
  logic [4:0]              lat_rd_r;
  logic [2:0]              lat_f3_r;
  logic [LANE_W-1:0]       lat_lo_r;
  logic                    rf_we_r;
  logic [4:0]              rf_waddr_r;
  logic [WORD_LENGTH-1:0]  rf_wdata_r;
  logic                    retire_r;
  logic [RETIRE_CNT_W-1:0] retire_cnt_r;

  logic [2:0]              ext_f3_s;
  logic [LANE_W-1:0]       ext_lo_s;
  logic [WORD_LENGTH-1:0]  ext_data_s;
  logic [WORD_LENGTH-1:0]  sel_data_s;

  // While waiting, the extender must see the latched load, not whatever MEM presents now.
  always_comb begin
    if (state_r == WAIT_MEM) begin
      ext_f3_s = lat_f3_r;
      ext_lo_s = lat_lo_r;
    end else begin
      ext_f3_s = ld_funct3;
      ext_lo_s = ld_addr_lo;
    end
  end

  riscv_load_ext #(
    .WORD_LENGTH (WORD_LENGTH)
  ) u_load_ext (
    .funct3  (ext_f3_s),
    .addr_lo (ext_lo_s),
    .rdata   (dmem_rdata),
    .ext     (ext_data_s)
  );

  // Non-memory writeback source select.
  always_comb begin
    sel_data_s = alu_out;
    case (wb_sel_t'(wb_sel))
      WB_PC:   sel_data_s = pc_plus4;
      WB_CSR:  sel_data_s = csr_dout;
      WB_ALU:  sel_data_s = alu_out;
      default: sel_data_s = alu_out;
    endcase
  end

  // Stage FSM with registered writeback, hazard and retire outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      lat_we_r     <= 1'b0;
      lat_rd_r     <= 5'd0;
      lat_f3_r     <= 3'd0;
      lat_lo_r     <= '0;
      rf_we_r      <= 1'b0;
      rf_waddr_r   <= 5'd0;
      rf_wdata_r   <= '0;
      retire_r     <= 1'b0;
      retire_cnt_r <= '0;
    end else begin
      rf_we_r  <= 1'b0;
      retire_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            if ((wb_sel == WB_MEM) && !dmem_rvalid) begin
              // Response not here yet: park the load and stall MEM.
              lat_we_r <= rd_we;
              lat_rd_r <= rd_addr;
              lat_f3_r <= ld_funct3;
              lat_lo_r <= ld_addr_lo;
              state_r  <= WAIT_MEM;
            end else begin
              rf_we_r      <= rf_write_en(rd_we, rd_addr);
              rf_waddr_r   <= rd_addr;
              rf_wdata_r   <= (wb_sel == WB_MEM) ? ext_data_s : sel_data_s;
              retire_r     <= 1'b1;
              retire_cnt_r <= retire_cnt_r + 1'b1;
            end
          end
        end
        WAIT_MEM: begin
          if (dmem_rvalid) begin
            rf_we_r      <= rf_write_en(lat_we_r, lat_rd_r);
            rf_waddr_r   <= lat_rd_r;
            rf_wdata_r   <= ext_data_s;
            retire_r     <= 1'b1;
            retire_cnt_r <= retire_cnt_r + 1'b1;
            state_r      <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign in_ready     = (state_r == IDLE);
  assign load_pending = (state_r == WAIT_MEM);
  assign load_rd      = (state_r == WAIT_MEM) ? lat_rd_r : 5'd0;
  assign rf_we        = rf_we_r;
  assign rf_waddr     = rf_waddr_r;
  assign rf_wdata     = rf_wdata_r;
  assign retire       = retire_r;
  assign retire_cnt   = retire_cnt_r;

endmodule

// File: tb/tb_riscv_wb_stage.sv
module tb_riscv_wb_stage;
  import riscv_constants::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        in_valid, in_ready, rd_we, dmem_rvalid;
  logic [1:0]  wb_sel, ld_addr_lo;
  logic [4:0]  rd_addr, rf_waddr, load_rd;
  logic [31:0] alu_out, pc_plus4, csr_dout, dmem_rdata, rf_wdata;
  logic [2:0]  ld_funct3;
  logic        rf_we, load_pending, retire;
  logic [63:0] retire_cnt;

  // 64-bit instance
  logic        v64, rdy64, we64, rv64;
  logic [1:0]  sel64;
  logic [2:0]  lo64, f364;
  logic [4:0]  rd64, waddr64, lrd64;
  logic [63:0] alu64, pc64, csr64, rdata64, wdata64;
  logic        rfwe64, pend64, ret64;
  logic [63:0] cnt64;

  riscv_wb_stage #(.WORD_LENGTH(32), .RETIRE_CNT_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .wb_sel(wb_sel), .rd_we(rd_we), .rd_addr(rd_addr), .alu_out(alu_out),
    .pc_plus4(pc_plus4), .csr_dout(csr_dout), .ld_funct3(ld_funct3),
    .ld_addr_lo(ld_addr_lo), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .load_pending(load_pending), .load_rd(load_rd), .retire(retire),
    .retire_cnt(retire_cnt)
  );

  riscv_wb_stage #(.WORD_LENGTH(64), .RETIRE_CNT_W(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(v64), .in_ready(rdy64),
    .wb_sel(sel64), .rd_we(we64), .rd_addr(rd64), .alu_out(alu64),
    .pc_plus4(pc64), .csr_dout(csr64), .ld_funct3(f364),
    .ld_addr_lo(lo64), .dmem_rvalid(rv64), .dmem_rdata(rdata64),
    .rf_we(rfwe64), .rf_waddr(waddr64), .rf_wdata(wdata64),
    .load_pending(pend64), .load_rd(lrd64), .retire(ret64),
    .retire_cnt(cnt64)
  );

  int tests = 0;
  int fails = 0;
  int exp_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [31:0] csr;
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic [31:0] rdata;
    logic        exp_we;
    logic [31:0] exp_wd;
  } vec_t;

  typedef struct {
    logic [2:0]  f3;
    logic [2:0]  lo;
    logic [63:0] rdata;
    logic [63:0] exp_wd;
  } vec64_t;

  vec_t   v[14];
  vec64_t w[5];

  initial begin
    // sel, we, rd, alu, pc, csr, f3, lo, rdata, exp_we, exp_wdata
    v[0]  = '{2'd0, 1'b1, 5'd5, 32'h0000_1234, 32'h0, 32'h0, 3'b000, 2'd0, 32'h0, 1'b1, 32'h0000_1234};
    v[1]  = '{2'd1, 1'b1, 5'd1, 32'h0, 32'h0, 32'h0, 3'b000, 2'd2, 32'h0080_0000, 1'b1, 32'hFFFF_FF80};
    v[2]  = '{2'd1, 1'b1, 5'd1, 32'h0, 32'h0, 32'h0, 3'b100, 2'd2, 32'h0080_0000, 1'b1, 32'h0000_0080};
    v[3]  = '{2'd1, 1'b1, 5'd2, 32'h0, 32'h0, 32'h0, 3'b001, 2'd2, 32'h8001_0000, 1'b1, 32'hFFFF_8001};
    v[4]  = '{2'd1, 1'b1, 5'd2, 32'h0, 32'h0, 32'h0, 3'b101, 2'd0, 32'h8001_7F00, 1'b1, 32'h0000_7F00};
    v[5]  = '{2'd1, 1'b1, 5'd6, 32'h0, 32'h0, 32'h0, 3'b010, 2'd0, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF};
    v[6]  = '{2'd1, 1'b1, 5'd6, 32'h0, 32'h0, 32'h0, 3'b110, 2'd1, 32'h8234_5678, 1'b1, 32'h8234_5678};
    v[7]  = '{2'd1, 1'b1, 5'd6, 32'h0, 32'h0, 32'h0, 3'b011, 2'd3, 32'h8765_4321, 1'b1, 32'h8765_4321};
    v[8]  = '{2'd1, 1'b1, 5'd8, 32'h0, 32'h0, 32'h0, 3'b111, 2'd1, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D};
    v[9]  = '{2'd2, 1'b1, 5'd0, 32'h1, 32'h0000_0100, 32'h2, 3'b000, 2'd0, 32'h0, 1'b0, 32'h0000_0100};
    v[10] = '{2'd3, 1'b1, 5'd3, 32'h1, 32'h2, 32'h0000_ABCD, 3'b000, 2'd0, 32'h0, 1'b1, 32'h0000_ABCD};
    v[11] = '{2'd0, 1'b0, 5'd9, 32'h5555_AAAA, 32'h0, 32'h0, 3'b000, 2'd0, 32'h0, 1'b0, 32'h5555_AAAA};
    v[12] = '{2'd1, 1'b1, 5'd4, 32'h0, 32'h0, 32'h0, 3'b000, 2'd3, 32'h7F00_0000, 1'b1, 32'h0000_007F};
    v[13] = '{2'd1, 1'b1, 5'd4, 32'h0, 32'h0, 32'h0, 3'b001, 2'd3, 32'h8001_0000, 1'b1, 32'hFFFF_8001};

    w[0] = '{3'b110, 3'd4, 64'h8000_0000_0000_0000, 64'h0000_0000_8000_0000};
    w[1] = '{3'b010, 3'd4, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_8000_0000};
    w[2] = '{3'b011, 3'd0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF};
    w[3] = '{3'b000, 3'd7, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FF80};
    w[4] = '{3'b001, 3'd6, 64'h8001_0000_0000_0000, 64'hFFFF_FFFF_FFFF_8001};

    in_valid = 1'b0; wb_sel = 2'd0; rd_we = 1'b0; rd_addr = 5'd0;
    alu_out = 32'h0; pc_plus4 = 32'h0; csr_dout = 32'h0; ld_funct3 = 3'd0;
    ld_addr_lo = 2'd0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    v64 = 1'b0; sel64 = 2'd1; we64 = 1'b1; rd64 = 5'd10; alu64 = 64'h0;
    pc64 = 64'h0; csr64 = 64'h0; f364 = 3'd0; lo64 = 3'd0; rv64 = 1'b0; rdata64 = 64'h0;

    // Reset state
    #1;
    chk("rst_rf_we", {63'd0, rf_we}, 64'd0);
    chk("rst_retire", {63'd0, retire}, 64'd0);
    chk("rst_cnt", retire_cnt, 64'd0);
    chk("rst_pending", {63'd0, load_pending}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back WB_PC (rd=0) then WB_CSR (rd=3)
    @(negedge clk);
    in_valid = 1'b1; wb_sel = WB_PC; rd_we = 1'b1; rd_addr = 5'd0; pc_plus4 = 32'h0000_0444;
    @(negedge clk);
    wb_sel = WB_CSR; rd_addr = 5'd3; csr_dout = 32'h1357_9BDF;
    chk("b2b_pc_we", {63'd0, rf_we}, 64'd0);
    chk("b2b_pc_retire", {63'd0, retire}, 64'd1);
    chk("b2b_pc_cnt", retire_cnt, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_csr_we", {63'd0, rf_we}, 64'd1);
    chk("b2b_csr_waddr", {59'd0, rf_waddr}, 64'd3);
    chk("b2b_csr_wdata", {32'd0, rf_wdata}, 64'h1357_9BDF);
    chk("b2b_csr_cnt", retire_cnt, 64'd2);
    exp_cnt = 2;

    // Table of single-cycle instructions
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      in_valid = 1'b1; wb_sel = v[i].sel; rd_we = v[i].we; rd_addr = v[i].rd;
      alu_out = v[i].alu; pc_plus4 = v[i].pc; csr_dout = v[i].csr;
      ld_funct3 = v[i].f3; ld_addr_lo = v[i].lo;
      dmem_rvalid = (v[i].sel == 2'd1); dmem_rdata = v[i].rdata;
      @(negedge clk);
      in_valid = 1'b0; dmem_rvalid = 1'b0;
      exp_cnt++;
      chk($sformatf("v%0d_we", i), {63'd0, rf_we}, {63'd0, v[i].exp_we});
      chk($sformatf("v%0d_waddr", i), {59'd0, rf_waddr}, {59'd0, v[i].rd});
      chk($sformatf("v%0d_wdata", i), {32'd0, rf_wdata}, {32'd0, v[i].exp_wd});
      chk($sformatf("v%0d_retire", i), {63'd0, retire}, 64'd1);
      chk($sformatf("v%0d_cnt", i), retire_cnt, 64'(exp_cnt));
    end

    // Stray response in IDLE without an accept is ignored
    @(negedge clk);
    dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    chk("stray_we", {63'd0, rf_we}, 64'd0);
    chk("stray_retire", {63'd0, retire}, 64'd0);
    chk("stray_cnt", retire_cnt, 64'(exp_cnt));

    // LH rd=7 with response delayed 3 cycles, next instruction held valid meanwhile
    @(negedge clk);
    in_valid = 1'b1; wb_sel = WB_MEM; rd_we = 1'b1; rd_addr = 5'd7;
    ld_funct3 = LH; ld_addr_lo = 2'd2; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      wb_sel = WB_ALU; rd_addr = 5'd4; alu_out = 32'h0000_0055;
      ld_funct3 = LB; ld_addr_lo = 2'd0;
      chk($sformatf("wait%0d_ready", c), {63'd0, in_ready}, 64'd0);
      chk($sformatf("wait%0d_pending", c), {63'd0, load_pending}, 64'd1);
      chk($sformatf("wait%0d_load_rd", c), {59'd0, load_rd}, 64'd7);
      chk($sformatf("wait%0d_retire", c), {63'd0, retire}, 64'd0);
      if (c == 2) begin
        dmem_rvalid = 1'b1; dmem_rdata = 32'h8001_0000;
      end
    end
    @(negedge clk);
    dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    exp_cnt++;
    chk("lh_we", {63'd0, rf_we}, 64'd1);
    chk("lh_waddr", {59'd0, rf_waddr}, 64'd7);
    chk("lh_wdata", {32'd0, rf_wdata}, 64'hFFFF_8001);
    chk("lh_cnt", retire_cnt, 64'(exp_cnt));
    chk("lh_ready", {63'd0, in_ready}, 64'd1);
    chk("lh_pending", {63'd0, load_pending}, 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    exp_cnt++;
    chk("held_waddr", {59'd0, rf_waddr}, 64'd4);
    chk("held_wdata", {32'd0, rf_wdata}, 64'h0000_0055);
    chk("held_cnt", retire_cnt, 64'(exp_cnt));

    // Reset while waiting for memory; a later response is ignored
    @(negedge clk);
    in_valid = 1'b1; wb_sel = WB_MEM; rd_addr = 5'd9; ld_funct3 = LB; dmem_rvalid = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rw_pending", {63'd0, load_pending}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rw_pending0", {63'd0, load_pending}, 64'd0);
    chk("rw_load_rd0", {59'd0, load_rd}, 64'd0);
    chk("rw_waddr0", {59'd0, rf_waddr}, 64'd0);
    chk("rw_wdata0", {32'd0, rf_wdata}, 64'd0);
    chk("rw_cnt0", retire_cnt, 64'd0);
    @(negedge clk);
    rst_n = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h0000_0011;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk($sformatf("post_rst%0d_we", c), {63'd0, rf_we}, 64'd0);
      chk($sformatf("post_rst%0d_retire", c), {63'd0, retire}, 64'd0);
      chk($sformatf("post_rst%0d_cnt", c), retire_cnt, 64'd0);
    end
    dmem_rvalid = 1'b0;

    // 64-bit build: word lanes and LD
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      v64 = 1'b1; rv64 = 1'b1; f364 = w[i].f3; lo64 = w[i].lo; rdata64 = w[i].rdata;
      @(negedge clk);
      v64 = 1'b0; rv64 = 1'b0;
      chk($sformatf("w%0d_wdata", i), wdata64, w[i].exp_wd);
      chk($sformatf("w%0d_we", i), {63'd0, rfwe64}, 64'd1);
      chk($sformatf("w%0d_cnt", i), cnt64, 64'(i + 1));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/riscv_wb_stage.md
Name: riscv_wb_stage

Overview:
Registered writeback stage for the kana-riscv core. It replaces the purely combinational writeback select with a pipelined stage. The stage accepts one retiring instruction per cycle from MEM over a valid/ready handshake. It waits for multi-cycle data-memory responses and performs load byte/half/word alignment and sign/zero extension. It drives the register-file write port, the forwarding/hazard signals and a retire counter.

Parameters:
WORD_LENGTH, 32, datapath width; only 32 and 64 are legal.
RETIRE_CNT_W, 64, width of the retired-instruction counter.
LANE_W, $clog2(WORD_LENGTH/8), derived; width of the load address low bits. Not overridable.

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  MEM stage presents an instruction
in_ready  output  1  stage can accept this cycle
wb_sel  input  WB_SEL  writeback source: WB_MEM, WB_PC, WB_CSR, otherwise ALU
rd_we  input  1  instruction writes rd
rd_addr  input  5  destination register
alu_out  input  WORD_LENGTH  ALU result
pc_plus4  input  WORD_LENGTH  link value
csr_dout  input  WORD_LENGTH  CSR read data
ld_funct3  input  3  load type (RV funct3)
ld_addr_lo  input  LANE_W  load byte offset within the word
dmem_rvalid  input  1  data-memory response valid
dmem_rdata  input  WORD_LENGTH  raw data-memory word
rf_we  output  1  register-file write enable
rf_waddr  output  5  register-file write address
rf_wdata  output  WORD_LENGTH  register-file write data
load_pending  output  1  a load is waiting for its memory response
load_rd  output  5  destination register of the pending load
retire  output  1  one-cycle pulse per retired instruction
retire_cnt  output  RETIRE_CNT_W  number of retired instructions

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While rst_n is low, every registered output is 0 and the state is IDLE.
- States:
  - IDLE: in_ready = 1.
  - WAIT_MEM: in_ready = 0.
- Accept condition: in_valid && in_ready.
- Accept in IDLE, wb_sel != WB_MEM: the registered outputs update at the next edge, so latency is 1 cycle.
- Accept with wb_sel == WB_MEM:
  - If dmem_rvalid is high in the same cycle, the data is captured directly (latency 1) and the state stays IDLE.
  - Otherwise, the instruction's rd_we, rd_addr, ld_funct3 and ld_addr_lo are latched and the state moves to WAIT_MEM.
- WAIT_MEM:
  - load_pending = 1 and load_rd = the latched rd.
  - On dmem_rvalid, the extended data is written at the next edge and the state returns to IDLE. in_ready rises in that same next cycle.
- dmem_rvalid is ignored in IDLE when no WB_MEM accept occurs.
- rf_we is a 1-cycle pulse equal to latched rd_we && (rd_addr != 0). Writes to x0 never assert rf_we, but the instruction still retires.
- retire pulses 1 cycle after every completed instruction, at the same edge as the rf_we opportunity. retire_cnt increments by 1 at that edge and wraps modulo 2^RETIRE_CNT_W.
- Load extension, with the lane selected by ld_addr_lo and data taken from dmem_rdata:
  - Byte lanes: the byte selected by ld_addr_lo.
  - Half lanes: the half selected by ld_addr_lo[LANE_W-1:1].
  - Word lanes: the word selected by ld_addr_lo[LANE_W-1:2] (64-bit only).
  - 000 LB: sign-extend byte.
  - 100 LBU: zero-extend byte.
  - 001 LH: sign-extend half.
  - 101 LHU: zero-extend half.
  - 010 LW: at 32 bits, pass the full word. At 64 bits, sign-extend the selected word.
  - 110 LWU: zero-extend word; 64-bit only.
  - 011 LD: pass the full word; 64-bit only.
  - Any other code, or a 64-bit-only code in a 32-bit build: pass dmem_rdata unchanged.
- Misaligned offsets (e.g. LH at offset 3) are not detected here; they are trapped upstream. The low LANE_W bits are used as-is.
- Reset mid-WAIT_MEM: the load is dropped and the state returns to IDLE. A response arriving after reset is ignored.

Decomposition:
- Package riscv_constants: WB_SEL enum (WB_ALU, WB_MEM, WB_PC, WB_CSR), LOAD_F3 localparams (LB, LH, LW, LD, LBU, LHU, LWU), and the wb_state_t enum (IDLE, WAIT_MEM).
- Sub-module riscv_load_ext: combinational, parametrised by WORD_LENGTH. Inputs are funct3, addr_lo and rdata; output is the extended word. Verified standalone.

Test Plan:
- ALU op, rd=5, alu_out=0x0000_1234, in_valid for 1 cycle -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234, retire=1, retire_cnt=1.
- LB, addr_lo=2, rdata=0x0080_0000, dmem_rvalid in the accept cycle -> next cycle rf_wdata=0xFFFF_FF80; LBU with the same stimulus -> 0x0000_0080.
- LH, rd=7, addr_lo=2, dmem_rvalid delayed 3 cycles with rdata=0x8001_0000:
  - in_ready=0 and load_pending=1 with load_rd=7 for those 3 cycles.
  - Then rf_wdata=0xFFFF_8001.
  - A second in_valid held throughout is accepted only after the write.
- Back-to-back WB_PC then WB_CSR, rd=0 then rd=3 -> first cycle rf_we=0 with retire=1; second cycle rf_we=1, rf_wdata=csr_dout; retire_cnt=2.
- rst_n pulled low while in WAIT_MEM -> all outputs 0 immediately. After rst_n is released, a stray dmem_rvalid produces no rf_we and no retire.
- WORD_LENGTH=64: LWU at addr_lo=4, rdata=0x8000_0000_0000_0000 -> rf_wdata=0x0000_0000_8000_0000; LW with the same stimulus -> 0xFFFF_FFFF_8000_0000.
